rle_dec: RTL and testbench

//  Run-length decoder; the stage downstream of the RLE encoder. Pops 24-bit words
//  {bit_id[23], run_len[22:0]} from the input-side FIFO and expands them back into
//  the original bit stream. Packs the stream into bytes, LSB first (stream bit 0
//  -> out_data[0]), and pushes each byte to the output-side FIFO.

---
 rtl/rle_pkg.sv | 29 ++
 rtl/rle_dec_pack.sv | 70 +++++++
 rtl/rle_dec.sv | 145 ++++++++++++++
 tb/tb_rle_dec.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared definitions for the RLE encoder/decoder pair: word layout, FSM states
// and a helper for the bit-position counter width.
package rle_pkg;

  localparam int COUNT_W = 23;
  localparam int DATA_W  = 8;
  localparam int WORD_W  = COUNT_W + 1;
  localparam int ID_BIT  = 23;
  localparam int RUN_MSB = 22;
  localparam int RUN_LSB = 0;

  typedef enum logic [3:0] {
    IDLE,
    REQUEST_INPUT,
    WAIT_INPUT,
    READ_INPUT,
    FILL,
    WRITE_OUTPUT,
    WAIT_OUTPUT,
    FLUSH,
    DONE
  } state_t;

  // One extra bit so the counter can hold DATA_W itself (byte full).
  function automatic int pos_width(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/rle_dec_pack.sv
// Byte packer for rle_dec: bit position, LSB-first out_data assembly and byte-full flag.
// RLE_DEC_FAST_FILL_EN: write min(run, room) bits per fill instead of one.
module rle_dec_pack #(
  parameter int COUNT_W = rle_pkg::COUNT_W,
  parameter int DATA_W  = rle_pkg::DATA_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  fill_en,
  input  logic                                  clear,
  input  logic                                  value,
  input  logic [COUNT_W-1:0]                    run,
  output logic [rle_pkg::pos_width(DATA_W)-1:0] take,
  output logic                                  byte_full,
  output logic [rle_pkg::pos_width(DATA_W)-1:0] bit_pos,
  output logic [DATA_W-1:0]                     out_data
);
  import rle_pkg::*;

  localparam int POS_W = pos_width(DATA_W);

  logic [POS_W-1:0]  bit_pos_reg;
  logic [DATA_W-1:0] data_reg;
  logic [POS_W-1:0]  end_pos;
  logic [DATA_W-1:0] mask;

`ifdef RLE_DEC_FAST_FILL_EN
  logic [POS_W-1:0] room;

  always_comb begin
    room = POS_W'(DATA_W) - bit_pos_reg;
    take = room;
    if (run < COUNT_W'(room)) begin
      take = run[POS_W-1:0];
    end
  end
`else
  always_comb begin
    take = (run == '0) ? '0 : POS_W'(1);
  end
`endif

  assign end_pos   = bit_pos_reg + take;
  assign byte_full = (end_pos == POS_W'(DATA_W));

  // Bits [end_pos-1:bit_pos] are the ones written this fill.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_mask
      assign mask[gi] = (POS_W'(gi) >= bit_pos_reg) && (POS_W'(gi) < end_pos);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_pos_reg <= '0;
      data_reg    <= '0;
    end else if (clear) begin
      bit_pos_reg <= '0;
      data_reg    <= '0;
    end else if (fill_en) begin
      bit_pos_reg <= end_pos;
      data_reg    <= value ? (data_reg | mask) : (data_reg & ~mask);
    end
  end

  assign bit_pos  = bit_pos_reg;
  assign out_data = data_reg;

endmodule

// File: rtl/rle_dec.sv
// Run-length decoder: pops {bit_id, run_len} words and re-emits the bit stream as LSB-first bytes.
// RLE_DEC_FAST_FILL_EN (in rle_dec_pack) selects multi-bit fill; byte stream is identical either way.
module rle_dec #(
  parameter int COUNT_W = rle_pkg::COUNT_W,
  parameter int DATA_W  = rle_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              recv_ready,
  input  logic              send_ready,
  input  logic [COUNT_W:0]  in_data,
  input  logic              end_of_stream,
  output logic              rd_req,
  output logic              wr_req,
  output logic [DATA_W-1:0] out_data,
  output logic              done
);
  import rle_pkg::*;

  localparam int POS_W = pos_width(DATA_W);

  state_t             state_reg, state_next;
  logic [COUNT_W-1:0] run_reg, run_next;
  logic               value_reg, value_next;
  logic               flush_reg, flush_next;
  logic               rd_req_reg, rd_req_next;
  logic               wr_req_reg, wr_req_next;
  logic               done_reg, done_next;

  logic               fill_en;
  logic               clear_byte;
  logic [POS_W-1:0]   take;
  logic               byte_full;
  logic [POS_W-1:0]   bit_pos;

  rle_dec_pack #(
    .COUNT_W (COUNT_W),
    .DATA_W  (DATA_W)
  ) u_pack (
    .clk       (clk),
    .rst       (rst),
    .fill_en   (fill_en),
    .clear     (clear_byte),
    .value     (value_reg),
    .run       (run_reg),
    .take      (take),
    .byte_full (byte_full),
    .bit_pos   (bit_pos),
    .out_data  (out_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      run_reg    <= '0;
      value_reg  <= 1'b0;
      flush_reg  <= 1'b0;
      rd_req_reg <= 1'b0;
      wr_req_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      run_reg    <= run_next;
      value_reg  <= value_next;
      flush_reg  <= flush_next;
      rd_req_reg <= rd_req_next;
      wr_req_reg <= wr_req_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    run_next    = run_reg;
    value_next  = value_reg;
    flush_next  = flush_reg;
    rd_req_next = 1'b0;
    wr_req_next = 1'b0;
    done_next   = 1'b0;
    fill_en     = 1'b0;
    clear_byte  = 1'b0;
    case (state_reg)
      IDLE: state_next = REQUEST_INPUT;
      // Pending words always take priority over end_of_stream.
      REQUEST_INPUT: begin
        if (recv_ready) begin
          rd_req_next = 1'b1;
          state_next  = WAIT_INPUT;
        end else if (end_of_stream) begin
          state_next = (bit_pos != '0) ? FLUSH : DONE;
        end
      end
      WAIT_INPUT: state_next = READ_INPUT;
      READ_INPUT: begin
        value_next = in_data[COUNT_W];
        run_next   = in_data[COUNT_W-1:0];
        state_next = (in_data[COUNT_W-1:0] == '0) ? REQUEST_INPUT : FILL;
      end
      FILL: begin
        fill_en  = 1'b1;
        run_next = run_reg - COUNT_W'(take);
        if (byte_full) begin
          state_next = WRITE_OUTPUT;
        end else if (run_next == '0) begin
          state_next = REQUEST_INPUT;
        end
      end
      WRITE_OUTPUT: begin
        if (send_ready) begin
          wr_req_next = 1'b1;
          state_next  = WAIT_OUTPUT;
        end
      end
      WAIT_OUTPUT: begin
        clear_byte = 1'b1;
        flush_next = 1'b0;
        if (flush_reg) begin
          state_next = DONE;
        end else if (run_reg != '0) begin
          state_next = FILL;
        end else begin
          state_next = REQUEST_INPUT;
        end
      end
      FLUSH: begin
        flush_next = 1'b1;
        state_next = WRITE_OUTPUT;
      end
      DONE: begin
        done_next  = 1'b1;
        run_next   = '0;
        value_next = 1'b0;
        flush_next = 1'b0;
        clear_byte = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rd_req = rd_req_reg;
  assign wr_req = wr_req_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_rle_dec.sv
// Directed self-checking bench for rle_dec with a small input-FIFO model and a byte monitor.
module tb_rle_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        recv_ready = 1'b0;
  logic        send_ready = 1'b1;
  logic [23:0] in_data = '0;
  logic        end_of_stream = 1'b0;
  logic        rd_req;
  logic        wr_req;
  logic [7:0]  out_data;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] fifo_mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [7:0]  got_q [$];
  int          rd_cnt = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  rle_dec dut (
    .clk           (clk),
    .rst           (rst),
    .recv_ready    (recv_ready),
    .send_ready    (send_ready),
    .in_data       (in_data),
    .end_of_stream (end_of_stream),
    .rd_req        (rd_req),
    .wr_req        (wr_req),
    .out_data      (out_data),
    .done          (done)
  );

  // Input FIFO model and output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rd_req) begin
      rd_cnt++;
      if (rd_ptr != wr_ptr) begin
        in_data = fifo_mem[rd_ptr % 64];
        rd_ptr++;
      end
    end
    if (wr_req) got_q.push_back(out_data);
    if (done) done_cnt++;
    recv_ready = (rd_ptr != wr_ptr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic push_word(input logic bit_id, input int run);
    fifo_mem[wr_ptr % 64] = {bit_id, 23'(run)};
    wr_ptr++;
  endtask

  task automatic wait_done(input string tag, input int done_base);
    int n = 0;
    while (done_cnt == done_base && n < 400) begin
      @(negedge clk);
      n++;
    end
    end_of_stream = 1'b0;
    check({tag, "_done_seen"}, 32'(done_cnt != done_base), 32'd1);
    repeat (6) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
  endtask

  task automatic expect_bytes(input string tag, input int base, input int n,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp [3];
    exp[0] = b0; exp[1] = b1; exp[2] = b2;
    check({tag, "_nbytes"}, 32'(got_q.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < got_q.size())
        check($sformatf("%s_byte%0d", tag, i), 32'(got_q[base + i]), 32'(exp[i]));
      else
        check($sformatf("%s_byte%0d", tag, i), 32'hFFFF_FFFF, 32'(exp[i]));
    end
  endtask

  initial begin
    int gb, db, rb;

    repeat (3) @(negedge clk);
    check("reset_rd_req", 32'(rd_req), 32'd0);
    check("reset_wr_req", 32'(wr_req), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 1: {1,8} -> 0xFF, one read
    gb = got_q.size(); db = done_cnt; rb = rd_cnt;
    push_word(1'b1, 8);
    end_of_stream = 1'b1;
    wait_done("t1", db);
    expect_bytes("t1", gb, 1, 8'hFF, 8'h00, 8'h00);
    check("t1_rd_pulses", 32'(rd_cnt - rb), 32'd1);

    // 2: {0,3},{1,5} -> 0xF8
    gb = got_q.size(); db = done_cnt; rb = rd_cnt;
    push_word(1'b0, 3);
    push_word(1'b1, 5);
    end_of_stream = 1'b1;
    wait_done("t2", db);
    expect_bytes("t2", gb, 1, 8'hF8, 8'h00, 8'h00);
    check("t2_rd_pulses", 32'(rd_cnt - rb), 32'd2);

    // 3: {1,20} -> 0xFF 0xFF 0x0F with zero pad
    gb = got_q.size(); db = done_cnt;
    push_word(1'b1, 20);
    end_of_stream = 1'b1;
    wait_done("t3", db);
    expect_bytes("t3", gb, 3, 8'hFF, 8'hFF, 8'h0F);

    // 4: output back-pressure holds the byte
    gb = got_q.size(); db = done_cnt;
    send_ready = 1'b0;
    push_word(1'b1, 8);
    end_of_stream = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_no_write_while_full", 32'(got_q.size() - gb), 32'd0);
    check("t4_held_data", 32'(out_data), 32'hFF);
    repeat (5) @(negedge clk);
    check("t4_still_no_write", 32'(got_q.size() - gb), 32'd0);
    check("t4_still_held", 32'(out_data), 32'hFF);
    send_ready = 1'b1;
    wait_done("t4", db);
    expect_bytes("t4", gb, 1, 8'hFF, 8'h00, 8'h00);

    // 5: zero-run word is discarded
    gb = got_q.size(); db = done_cnt; rb = rd_cnt;
    push_word(1'b0, 4);
    push_word(1'b1, 0);
    push_word(1'b1, 4);
    end_of_stream = 1'b1;
    wait_done("t5", db);
    expect_bytes("t5", gb, 1, 8'hF0, 8'h00, 8'h00);
    check("t5_rd_pulses", 32'(rd_cnt - rb), 32'd3);

    // 6: reset mid-fill, then a fresh word decodes cleanly
    push_word(1'b1, 20);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_rst_rd_req", 32'(rd_req), 32'd0);
    check("t6_rst_wr_req", 32'(wr_req), 32'd0);
    check("t6_rst_out_data", 32'(out_data), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    gb = got_q.size(); db = done_cnt;
    push_word(1'b0, 8);
    end_of_stream = 1'b1;
    wait_done("t6", db);
    expect_bytes("t6", gb, 1, 8'h00, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
